// File: rtl/bnn_ctrl_seq.sv
// bnn_ctrl_seq: top-level sequencer for the binary CNN accelerator.
// Runs first-layer convolution over the serial image, second-layer
// convolution over the buffered feature maps, then a serial argmax over the
// fully-connected scores.
module bnn_ctrl_seq #(
  parameter int CH          = 2,
  parameter int FMAP_DEPTH  = 676,
  parameter int W_TAPS      = 9,
  parameter int NUM_CLASSES = 10,
  parameter int SCORE_W     = 10
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic                           start,
  input  logic                           pic_din,
  input  logic [CH-1:0]                  conv_result,
  input  logic [CH-1:0]                  conv_result_valid,
  input  logic [CH-1:0]                  conv_done,
  input  logic [NUM_CLASSES*SCORE_W-1:0] fc_scores,
  input  logic                           fc_result_valid,
  output logic [CH-1:0]                  conv_din,
  output logic                           conv_start,
  output logic [CH-1:0]                  weight_en,
  output logic                           stage,
  output logic [$clog2(CH+1)-1:0]        conv_sum,
  output logic                           maxpool_valid,
  output logic [NUM_CLASSES-1:0]         classes,
  output logic [$clog2(NUM_CLASSES)-1:0] class_idx,
  output logic                           done,
  output logic                           busy,
  output logic                           fmap_ovf
);

  localparam int          WPW  = $clog2(FMAP_DEPTH + 1);
  localparam int          RPW  = (FMAP_DEPTH > 1) ? $clog2(FMAP_DEPTH) : 1;
  localparam int          WMAX = CH * W_TAPS;
  localparam int          WCW  = $clog2(WMAX + 1);
  localparam int          SUMW = $clog2(CH + 1);
  localparam int          CW   = $clog2(NUM_CLASSES);
  localparam int          SCW  = NUM_CLASSES * SCORE_W;
  localparam int unsigned WT   = W_TAPS;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CONV1,
    S_CONV2,
    S_CLASSIFY,
    S_DONE
  } state_e;

  state_e                    state_q;
  logic [SCW-1:0]            scores_q;
  logic [CW-1:0]             cls_cnt_q;
  logic signed [SCORE_W-1:0] best_val_q, best_val_d, cur_score;
  logic [CW-1:0]             best_idx_q, best_idx_d;
  logic [NUM_CLASSES-1:0]    onehot_d;
  logic [NUM_CLASSES-1:0]    classes_q;
  logic [CW-1:0]             class_idx_q;
  logic                      done_q;

  logic [WPW-1:0]            wr_ptr_q [CH];
  logic [RPW-1:0]            rd_ptr_q [CH];
  logic [FMAP_DEPTH-1:0]     fmap_q   [CH];
  logic                      fmap_ovf_q;

  logic [WCW-1:0]            wcnt_q;
  logic [CH-1:0]             weight_en_q, weight_en_d;
  logic [SUMW-1:0]           conv_sum_q, conv_sum_d;
  logic                      maxpool_valid_q;

  // Conv enable and per-channel serial data source
  always_comb begin
    conv_start = ((state_q == S_CONV1) || (state_q == S_CONV2)) && (conv_done == '0);
    conv_din   = '0;
    for (int unsigned c = 0; c < CH; c++) begin
      if (state_q == S_CONV1) begin
        conv_din[c] = pic_din;
      end else if (state_q == S_CONV2) begin
        conv_din[c] = fmap_q[c][rd_ptr_q[c]];
      end
    end
  end

  // Running argmax candidate for the class examined this cycle
  always_comb begin
    cur_score = scores_q[32'(cls_cnt_q) * SCORE_W +: SCORE_W];
    if ((cls_cnt_q == '0) || (cur_score > best_val_q)) begin
      best_val_d = cur_score;
      best_idx_d = cls_cnt_q;
    end else begin
      best_val_d = best_val_q;
      best_idx_d = best_idx_q;
    end
    onehot_d             = '0;
    onehot_d[best_idx_d] = 1'b1;
  end

  // Phase sequencing, score latch and serial argmax
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= S_IDLE;
      scores_q    <= '0;
      cls_cnt_q   <= '0;
      best_val_q  <= '0;
      best_idx_q  <= '0;
      classes_q   <= '0;
      class_idx_q <= '0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) state_q <= S_CONV1;
        end
        S_CONV1: begin
          if (&conv_done) state_q <= S_CONV2;
        end
        S_CONV2: begin
          if (fc_result_valid) begin
            scores_q  <= fc_scores;
            cls_cnt_q <= '0;
            state_q   <= S_CLASSIFY;
          end
        end
        S_CLASSIFY: begin
          best_val_q <= best_val_d;
          best_idx_q <= best_idx_d;
          if (cls_cnt_q == CW'(NUM_CLASSES - 1)) begin
            classes_q   <= onehot_d;
            class_idx_q <= best_idx_d;
            done_q      <= 1'b1;
            state_q     <= S_DONE;
          end else begin
            cls_cnt_q <= cls_cnt_q + CW'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Feature-map buffers: write during CONV1, replay during CONV2
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int unsigned c = 0; c < CH; c++) begin
        wr_ptr_q[c] <= '0;
        rd_ptr_q[c] <= '0;
        fmap_q[c]   <= '0;
      end
      fmap_ovf_q <= 1'b0;
    end else begin
      if ((state_q == S_IDLE) && start) begin
        for (int unsigned c = 0; c < CH; c++) begin
          wr_ptr_q[c] <= '0;
          rd_ptr_q[c] <= '0;
        end
        fmap_ovf_q <= 1'b0;
      end
      if (state_q == S_CONV1) begin
        for (int unsigned c = 0; c < CH; c++) begin
          if (conv_result_valid[c]) begin
            if (wr_ptr_q[c] < WPW'(FMAP_DEPTH)) begin
              fmap_q[c][wr_ptr_q[c]] <= conv_result[c];
              wr_ptr_q[c]            <= wr_ptr_q[c] + WPW'(1);
            end else begin
              fmap_ovf_q <= 1'b1;
            end
          end
        end
        if (&conv_done) begin
          for (int unsigned c = 0; c < CH; c++) rd_ptr_q[c] <= '0;
        end
      end
      if ((state_q == S_CONV2) && conv_start) begin
        for (int unsigned c = 0; c < CH; c++) begin
          if (rd_ptr_q[c] == RPW'(FMAP_DEPTH - 1)) rd_ptr_q[c] <= '0;
          else                                     rd_ptr_q[c] <= rd_ptr_q[c] + RPW'(1);
        end
      end
    end
  end

  // Weight-load window decode: channel c owns taps [c*W_TAPS, (c+1)*W_TAPS)
  always_comb begin
    weight_en_d = '0;
    for (int unsigned c = 0; c < CH; c++) begin
      if (conv_start && (32'(wcnt_q) >= c * WT) && (32'(wcnt_q) < (c + 1) * WT)) begin
        weight_en_d[c] = 1'b1;
      end
    end
  end

  // Weight tap counter and registered one-hot load enable
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wcnt_q      <= '0;
      weight_en_q <= '0;
    end else begin
      weight_en_q <= weight_en_d;
      if (!conv_start)                wcnt_q <= '0;
      else if (wcnt_q < WCW'(WMAX))   wcnt_q <= wcnt_q + WCW'(1);
    end
  end

  // Popcount of the per-channel conv outputs
  always_comb begin
    conv_sum_d = '0;
    for (int unsigned c = 0; c < CH; c++) conv_sum_d = conv_sum_d + SUMW'(conv_result[c]);
  end

  // Registered channel sum and its max-pool qualifier
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      conv_sum_q      <= '0;
      maxpool_valid_q <= 1'b0;
    end else begin
      conv_sum_q      <= conv_sum_d;
      maxpool_valid_q <= (state_q == S_CONV2) && (&conv_result_valid);
    end
  end

  // stage is held low in IDLE so every output reads 0 out of reset
  assign stage         = (state_q == S_CONV2) || (state_q == S_CLASSIFY) || (state_q == S_DONE);
  assign busy          = (state_q != S_IDLE);
  assign done          = done_q;
  assign classes       = classes_q;
  assign class_idx     = class_idx_q;
  assign fmap_ovf      = fmap_ovf_q;
  assign weight_en     = weight_en_q;
  assign conv_sum      = conv_sum_q;
  assign maxpool_valid = maxpool_valid_q;

endmodule

// File: tb/tb_bnn_ctrl_seq.sv
// tb_bnn_ctrl_seq: randomized self-checking bench for bnn_ctrl_seq with a
// phase-level behavioural model (feature maps as bit arrays, argmax computed
// directly over the latched scores).
module tb_bnn_ctrl_seq;

  localparam int CH          = 2;
  localparam int FMAP_DEPTH  = 676;
  localparam int W_TAPS      = 9;
  localparam int NUM_CLASSES = 10;
  localparam int SCORE_W     = 10;
  localparam int SUMW        = $clog2(CH + 1);
  localparam int CW          = $clog2(NUM_CLASSES);
  localparam int SCW         = NUM_CLASSES * SCORE_W;

  logic                   clk = 1'b0;
  logic                   rstn = 1'b0;
  logic                   start = 1'b0;
  logic                   pic_din = 1'b0;
  logic [CH-1:0]          conv_result = '0;
  logic [CH-1:0]          conv_result_valid = '0;
  logic [CH-1:0]          conv_done = '0;
  logic [SCW-1:0]         fc_scores = '0;
  logic                   fc_result_valid = 1'b0;
  logic [CH-1:0]          conv_din;
  logic                   conv_start;
  logic [CH-1:0]          weight_en;
  logic                   stage;
  logic [SUMW-1:0]        conv_sum;
  logic                   maxpool_valid;
  logic [NUM_CLASSES-1:0] classes;
  logic [CW-1:0]          class_idx;
  logic                   done;
  logic                   busy;
  logic                   fmap_ovf;

  always #5 clk = ~clk;

  bnn_ctrl_seq #(
    .CH(CH), .FMAP_DEPTH(FMAP_DEPTH), .W_TAPS(W_TAPS),
    .NUM_CLASSES(NUM_CLASSES), .SCORE_W(SCORE_W)
  ) dut (
    .clk(clk), .rstn(rstn), .start(start), .pic_din(pic_din),
    .conv_result(conv_result), .conv_result_valid(conv_result_valid),
    .conv_done(conv_done), .fc_scores(fc_scores), .fc_result_valid(fc_result_valid),
    .conv_din(conv_din), .conv_start(conv_start), .weight_en(weight_en),
    .stage(stage), .conv_sum(conv_sum), .maxpool_valid(maxpool_valid),
    .classes(classes), .class_idx(class_idx), .done(done), .busy(busy),
    .fmap_ovf(fmap_ovf)
  );

  int n_tot = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  // Behavioural model: 0 idle, 1 conv1, 2 conv2, 3 classify, 4 done
  int                     ph;
  int                     cls_left;
  int                     run;
  int                     wr [CH];
  int                     rd [CH];
  bit                     ovf_m;
  bit                     fm [CH][FMAP_DEPTH];
  logic [CH-1:0]          e_wen;
  int                     e_sum;
  bit                     e_mp;
  logic [NUM_CLASSES-1:0] e_cls;
  int                     e_idx;
  int                     pend_idx;
  bit                     e_done;
  int                     cyc = 0;
  int                     strobe_cyc = -1;
  int                     done_cyc = -1;

  task automatic model_reset();
    ph = 0; cls_left = 0; run = 0; ovf_m = 0;
    for (int c = 0; c < CH; c++) begin
      wr[c] = 0; rd[c] = 0;
      for (int a = 0; a < FMAP_DEPTH; a++) fm[c][a] = 1'b0;
    end
    e_wen = '0; e_sum = 0; e_mp = 0; e_cls = '0; e_idx = 0; pend_idx = 0; e_done = 0;
  endtask

  function automatic int argmax(input logic [SCW-1:0] v);
    int best;
    int bv;
    int x;
    logic signed [SCORE_W-1:0] t;
    best = 0;
    t = v[0 +: SCORE_W];
    bv = t;
    for (int k = 1; k < NUM_CLASSES; k++) begin
      t = v[k*SCORE_W +: SCORE_W];
      x = t;
      if (x > bv) begin
        bv = x;
        best = k;
      end
    end
    return best;
  endfunction

  function automatic logic [SCW-1:0] pack(input int s[NUM_CLASSES]);
    logic [SCW-1:0] v;
    v = '0;
    for (int k = 0; k < NUM_CLASSES; k++) v[k*SCORE_W +: SCORE_W] = SCORE_W'(s[k]);
    return v;
  endfunction

  // One clock cycle: check registered outputs, drive inputs, check the
  // combinational outputs, advance the model, then cross the next edge.
  task automatic cycle(input bit st, input bit pic, input logic [CH-1:0] res,
                       input logic [CH-1:0] val, input logic [CH-1:0] cd,
                       input bit fcv, input logic [SCW-1:0] sc);
    bit            cs;
    logic [CH-1:0] din_e;
    chk("busy", busy, ph != 0);
    chk("done", done, e_done);
    if (done === 1'b1) done_cyc = cyc;
    chk("classes", classes, e_cls);
    chk("class_idx", class_idx, e_idx);
    chk("fmap_ovf", fmap_ovf, ovf_m);
    chk("weight_en", weight_en, e_wen);
    chk("conv_sum", conv_sum, e_sum);
    chk("maxpool_valid", maxpool_valid, e_mp);
    if (ph == 1 || ph == 2) chk("stage", stage, ph == 2);

    start = st; pic_din = pic; conv_result = res; conv_result_valid = val;
    conv_done = cd; fc_result_valid = fcv; fc_scores = sc;
    #1;
    cs = (ph == 1 || ph == 2) && (cd == '0);
    chk("conv_start", conv_start, cs);
    for (int c = 0; c < CH; c++) din_e[c] = (ph == 1) ? pic : (ph == 2) ? fm[c][rd[c]] : 1'b0;
    chk("conv_din", conv_din, din_e);

    e_sum = $countones(res);
    e_mp  = (ph == 2) && (&val);
    e_wen = '0;
    if (cs && run < CH * W_TAPS) e_wen[run / W_TAPS] = 1'b1;
    run = cs ? ((run < CH * W_TAPS) ? run + 1 : run) : 0;
    e_done = 0;
    case (ph)
      0: if (st) begin
        ph = 1; ovf_m = 0;
        for (int c = 0; c < CH; c++) begin wr[c] = 0; rd[c] = 0; end
      end
      1: begin
        for (int c = 0; c < CH; c++) begin
          if (val[c]) begin
            if (wr[c] < FMAP_DEPTH) begin
              fm[c][wr[c]] = res[c];
              wr[c]++;
            end else begin
              ovf_m = 1;
            end
          end
        end
        if (&cd) begin
          ph = 2;
          for (int c = 0; c < CH; c++) rd[c] = 0;
        end
      end
      2: begin
        if (cs) for (int c = 0; c < CH; c++) rd[c] = (rd[c] + 1) % FMAP_DEPTH;
        if (fcv) begin
          pend_idx = argmax(sc); cls_left = NUM_CLASSES; ph = 3; strobe_cyc = cyc;
        end
      end
      3: begin
        cls_left--;
        if (cls_left == 0) begin
          e_idx = pend_idx; e_cls = '0; e_cls[pend_idx] = 1'b1; e_done = 1; ph = 4;
        end
      end
      default: ph = 0;
    endcase
    @(posedge clk);
    #2;
    cyc++;
  endtask

  function automatic logic [SCW-1:0] rand_scores(input bit narrow);
    int s[NUM_CLASSES];
    for (int k = 0; k < NUM_CLASSES; k++)
      s[k] = narrow ? int'($urandom_range(0, 8)) - 4 : int'($urandom_range(0, 1023)) - 512;
    return pack(s);
  endfunction

  initial begin
    int            sA[NUM_CLASSES] = '{-512, 3, 7, 7, -1, 0, 0, 0, 0, 0};
    int            sB[NUM_CLASSES] = '{-512, -512, -512, -512, -512, -512, -512, -512, -512, -512};
    int            n0;
    int            n1;
    int            guard;
    logic [CH-1:0] r;
    logic [CH-1:0] v;

    model_reset();
    repeat (3) @(posedge clk);
    #2;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_conv_start", conv_start, 0);
    chk("rst_conv_din", conv_din, 0);
    chk("rst_weight_en", weight_en, 0);
    chk("rst_classes", classes, 0);
    chk("rst_class_idx", class_idx, 0);
    chk("rst_fmap_ovf", fmap_ovf, 0);
    chk("rst_conv_sum", conv_sum, 0);
    chk("rst_maxpool", maxpool_valid, 0);
    chk("rst_stage", stage, 0);
    rstn = 1'b1;
    repeat (2) cycle(0, 0, '0, '0, '0, 0, '0);

    // Run A: overflow on channel 0, replay with wrap, fixed score vector
    cycle(1, 0, '0, '0, '0, 0, '0);
    n0 = 0; n1 = 0; guard = 0;
    while ((n0 < FMAP_DEPTH + 1 || n1 < FMAP_DEPTH) && guard < 5000) begin
      r = CH'($urandom);
      v[0] = ($urandom_range(0, 3) != 0) && (n0 < FMAP_DEPTH + 1);
      v[1] = ($urandom_range(0, 3) != 0) && (n1 < FMAP_DEPTH);
      if (guard == 3) begin r = '1; v = '1; end
      n0 += int'(v[0]); n1 += int'(v[1]);
      cycle(1'($urandom), 1'($urandom), r, v, '0, 1'($urandom), rand_scores(0));
      if (guard == 3) chk("mp_conv1_allones", maxpool_valid, 0);
      guard++;
    end
    cycle(0, 0, '0, '0, '0, 0, '0);
    chk("ovf_A", fmap_ovf, 1);
    cycle(0, 0, '0, '0, '1, 0, '0);
    cycle(0, 0, '0, '0, '1, 0, '0);
    for (int j = 0; j < FMAP_DEPTH + 6; j++) begin
      r = CH'($urandom); v = CH'($urandom);
      if (j % 50 == 7) begin r = '1; v = '1; end
      cycle(1'($urandom), 1'($urandom), r, v, '0, 0, rand_scores(0));
    end
    cycle(0, 0, '1, '1, '0, 0, '0);
    chk("mp_conv2_allones", maxpool_valid, 1);
    chk("sum_conv2_allones", conv_sum, CH);
    cycle(0, 0, '0, '0, '0, 1, pack(sA));
    for (int j = 0; j < 13; j++) cycle(0, 0, '0, '0, '0, 1'($urandom), rand_scores(0));
    chk("classes_A", classes, 10'b0000000100);
    chk("class_idx_A", class_idx, 2);
    chk("done_latency_A", done_cyc - strobe_cyc, NUM_CLASSES + 1);

    // Run B: all scores equal at the minimum value
    cycle(1, 0, '0, '0, '0, 0, '0);
    repeat (3) cycle(0, 1'($urandom), CH'($urandom), CH'($urandom), '0, 0, '0);
    cycle(0, 0, '0, '0, '1, 0, '0);
    repeat (3) cycle(0, 0, CH'($urandom), CH'($urandom), '0, 0, '0);
    cycle(0, 0, '0, '0, '0, 1, pack(sB));
    repeat (13) cycle(0, 0, '0, '0, '0, 0, '0);
    chk("classes_B", classes, 10'b0000000001);
    chk("class_idx_B", class_idx, 0);

    // Run C: reset mid-CONV2, then a normal run
    cycle(1, 0, '0, '0, '0, 0, '0);
    repeat (4) cycle(0, 1'($urandom), CH'($urandom), CH'($urandom), '0, 0, '0);
    cycle(0, 0, '0, '0, '1, 0, '0);
    repeat (5) cycle(0, 0, CH'($urandom), CH'($urandom), '0, 0, '0);
    conv_result = '0; conv_result_valid = '0; conv_done = '0; start = 0; fc_result_valid = 0;
    rstn = 1'b0;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_conv_start", conv_start, 0);
    chk("midrst_conv_din", conv_din, 0);
    chk("midrst_weight_en", weight_en, 0);
    chk("midrst_classes", classes, 0);
    chk("midrst_class_idx", class_idx, 0);
    chk("midrst_done", done, 0);
    chk("midrst_stage", stage, 0);
    @(posedge clk);
    #2;
    chk("midrst_done_held", done, 0);
    rstn = 1'b1;
    model_reset();

    // Randomized runs
    for (int k = 0; k < 6; k++) begin
      repeat ($urandom_range(0, 2)) cycle(0, 0, '0, '0, CH'($urandom), 0, '0);
      cycle(1, 0, '0, '0, '0, 0, '0);
      repeat ($urandom_range(2, 40))
        cycle(1'($urandom), 1'($urandom), CH'($urandom), CH'($urandom),
              ($urandom_range(0, 5) == 0) ? 2'b01 : 2'b00, 1'($urandom), '0);
      cycle(0, 0, CH'($urandom), CH'($urandom), '1, 0, '0);
      repeat ($urandom_range(0, 30))
        cycle(1'($urandom), 1'($urandom), CH'($urandom), CH'($urandom),
              ($urandom_range(0, 5) == 0) ? CH'($urandom) : '0, 0, rand_scores(0));
      cycle(0, 0, '0, '0, '0, 1, rand_scores(k % 2 == 0));
      repeat (13) cycle(1'($urandom), 0, CH'($urandom), CH'($urandom), '0, 1'($urandom), rand_scores(0));
    end

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
